// File: rtl/alu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared constants for the execute-stage ALU control and its multiply/divide
// sequencer: ALUOp classes, R-type Funct codes, I-type OpCodes, the 4-bit
// ALUSel encoding (legacy 3-bit codes keep their values) and the sequencer
// state type.
// ---------------------------------------------------------------------------
package alu_ctrl_pkg;

    // ALUOp classes from main control
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    // R-type function field
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;

    // I-type opcodes that select something other than ADD
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    // ALUSel encodings
    localparam logic [3:0] SEL_ADD     = 4'b0000;
    localparam logic [3:0] SEL_SUB     = 4'b0001;
    localparam logic [3:0] SEL_AND     = 4'b0010;
    localparam logic [3:0] SEL_OR      = 4'b0011;
    localparam logic [3:0] SEL_XOR     = 4'b0100;
    localparam logic [3:0] SEL_NOR     = 4'b0101;
    localparam logic [3:0] SEL_SLTU    = 4'b0110;
    localparam logic [3:0] SEL_SLT     = 4'b0111;
    localparam logic [3:0] SEL_SLL     = 4'b1000;
    localparam logic [3:0] SEL_SRL     = 4'b1001;
    localparam logic [3:0] SEL_SRA     = 4'b1010;
    localparam logic [3:0] SEL_LUI     = 4'b1011;
    localparam logic [3:0] SEL_PASS_HI = 4'b1100;
    localparam logic [3:0] SEL_PASS_LO = 4'b1101;

    // Multiply/divide sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } md_state_e;

    // True for every Funct that touches HI/LO (and so may collide with the
    // sequencer).
    function automatic logic is_md_funct(input logic [5:0] f);
        return (f == FN_MULT) || (f == FN_MULTU) || (f == FN_DIV)  ||
               (f == FN_DIVU) || (f == FN_MFHI)  || (f == FN_MTHI) ||
               (f == FN_MFLO) || (f == FN_MTLO);
    endfunction

endpackage

// File: rtl/md_iter.sv
// ---------------------------------------------------------------------------
// md_iter
// Datapath of the iterative multiply/divide unit. Magnitudes are latched on
// start, then one radix-2 step runs per cycle while the parent holds MUL or
// DIV; fix_hi/fix_lo present the sign-corrected result for the FIX cycle.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   state           sequencer state from the parent
//   start           load operands this cycle (MULT/MULTU/DIV/DIVU accepted)
//   start_div       operation being started is a divide
//   start_signed    operation being started is signed (MULT/DIV)
//   op_a, op_b      rs / rt operands
//   fix_hi, fix_lo  sign-corrected HI/LO result, valid in FIX
// ---------------------------------------------------------------------------
module md_iter
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  md_state_e        state,
    input  logic             start,
    input  logic             start_div,
    input  logic             start_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] fix_hi,
    output logic [WIDTH-1:0] fix_lo
);

    // p_hi:p_lo is the product accumulator (multiply) or remainder:quotient
    // (divide); m is the multiplicand or divisor magnitude.
    logic [WIDTH-1:0]   p_hi, p_lo, m;
    logic               neg_q, neg_r, is_div;

    logic               a_neg, b_neg, b_zero;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod_neg;

    // NOTE: every always_comb output is assigned on every path (here
    // unconditionally, below via defaults first) so no latch is inferred.
    always_comb begin
        a_neg  = start_signed & op_a[WIDTH-1];
        b_neg  = start_signed & op_b[WIDTH-1];
        b_zero = start_div & (op_b == '0);
        // With a zero divisor the raw dividend must come out as the
        // remainder, so its magnitude is not taken.
        a_mag  = (a_neg & ~b_zero) ? -op_a : op_a;
        b_mag  = b_neg ? -op_b : op_b;
    end

    // Shift-add multiply step: add multiplicand when the multiplier LSB is 1.
    assign mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, m} : '0);

    // Restoring divide step: shift in the next dividend bit, subtract if it
    // fits. When it fits the difference is below m, so WIDTH bits suffice.
    assign div_shift = {p_hi, p_lo[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, m};
    assign div_diff  = div_shift[WIDTH-1:0] - m;

    assign prod_neg  = -{p_hi, p_lo};

    always_comb begin
        fix_hi = p_hi;
        fix_lo = p_lo;
        if (is_div) begin
            if (neg_q) fix_lo = -p_lo;
            if (neg_r) fix_hi = -p_hi;
        end else if (neg_q) begin
            {fix_hi, fix_lo} = prod_neg;
        end
    end

    // NOTE: sequential state is written with non-blocking assignments so all
    // registers update together from pre-edge values.
    // NOTE: the datapath registers are reset as well; they are few and this
    // keeps HI/LO X-free if a flushed operation is ever observed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_hi   <= '0;
            p_lo   <= '0;
            m      <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            is_div <= 1'b0;
        end else if (start) begin
            p_hi   <= '0;
            p_lo   <= start_div ? a_mag : b_mag;
            m      <= start_div ? b_mag : a_mag;
            is_div <= start_div;
            // Divide by zero bypasses sign correction entirely.
            neg_q  <= ~b_zero & (a_neg ^ b_neg);
            neg_r  <= ~b_zero & a_neg;
        end else if (state == MUL) begin
            {p_hi, p_lo} <= {mul_sum, p_lo[WIDTH-1:1]};
        end else if (state == DIV) begin
            p_hi <= div_ge ? div_diff : div_shift[WIDTH-1:0];
            p_lo <= {p_lo[WIDTH-2:0], div_ge};
        end
    end

endmodule

// File: rtl/alu_control_md.sv
// ---------------------------------------------------------------------------
// alu_control_md
// Execute-stage ALU control: decodes ALUOp/Funct/OpCode into ALUSel and runs
// MULT/MULTU/DIV/DIVU iteratively (WIDTH steps plus a fixup cycle) into the
// HI/LO registers. Only HI/LO-class instructions stall, and only while the
// sequencer is busy.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   ALUOp         class from main control
//   Funct         R-type function field
//   OpCode        instruction opcode
//   ex_valid      execute stage holds a live instruction
//   flush         abort in-flight multiply/divide, block acceptance
//   op_a, op_b    rs / rt operands
//   ALUSel        ALU operation select (combinational)
//   stall         hold the execute stage (combinational)
//   md_busy       sequencer not idle (registered)
//   hi, lo        HI / LO registers
// ---------------------------------------------------------------------------
module alu_control_md
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       Funct,
    input  logic [5:0]       OpCode,
    input  logic             ex_valid,
    input  logic             flush,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [SEL_W-1:0] ALUSel,
    output logic             stall,
    output logic             md_busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int                CNT_W   = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(WIDTH - 1);

    md_state_e        state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             md_class, accept, f_mul, f_div, start, start_signed;
    logic [WIDTH-1:0] fix_hi, fix_lo;

    // ---------------- ALU select decode ----------------
    always_comb begin
        ALUSel = SEL_ADD;
        case (ALUOp)
            ALUOP_ADD: ALUSel = SEL_ADD;
            ALUOP_SUB: ALUSel = SEL_SUB;
            ALUOP_RTYPE: begin
                case (Funct)
                    FN_ADD, FN_ADDU: ALUSel = SEL_ADD;
                    FN_SUB, FN_SUBU: ALUSel = SEL_SUB;
                    FN_AND:          ALUSel = SEL_AND;
                    FN_OR:           ALUSel = SEL_OR;
                    FN_XOR:          ALUSel = SEL_XOR;
                    FN_NOR:          ALUSel = SEL_NOR;
                    FN_SLT:          ALUSel = SEL_SLT;
                    FN_SLTU:         ALUSel = SEL_SLTU;
                    FN_SLL:          ALUSel = SEL_SLL;
                    FN_SRL:          ALUSel = SEL_SRL;
                    FN_SRA:          ALUSel = SEL_SRA;
                    FN_MFHI:         ALUSel = SEL_PASS_HI;
                    FN_MFLO:         ALUSel = SEL_PASS_LO;
                    default:         ALUSel = SEL_ADD;
                endcase
            end
            ALUOP_ITYPE: begin
                case (OpCode)
                    OP_SLTI:  ALUSel = SEL_SLT;
                    OP_SLTIU: ALUSel = SEL_SLTU;
                    OP_ANDI:  ALUSel = SEL_AND;
                    OP_ORI:   ALUSel = SEL_OR;
                    OP_XORI:  ALUSel = SEL_XOR;
                    OP_LUI:   ALUSel = SEL_LUI;
                    default:  ALUSel = SEL_ADD;
                endcase
            end
            default: ALUSel = SEL_ADD;
        endcase
    end

    // ---------------- HI/LO class handling ----------------
    assign md_class     = (ALUOp == ALUOP_RTYPE) && is_md_funct(Funct);
    assign accept       = (state == IDLE) && ex_valid && md_class && !flush;
    assign f_mul        = (Funct == FN_MULT) || (Funct == FN_MULTU);
    assign f_div        = (Funct == FN_DIV)  || (Funct == FN_DIVU);
    assign start        = accept && (f_mul || f_div);
    assign start_signed = (Funct == FN_MULT) || (Funct == FN_DIV);

    // The accepting instruction sees md_busy low, so it is never stalled.
    assign stall = ex_valid && md_class && md_busy;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = f_div ? DIV : MUL;
                    cnt_d   = CNT_MAX;
                end
            end
            MUL, DIV: begin
                if (flush)             state_d = IDLE;
                else if (cnt == '0)    state_d = FIX;
                else                   cnt_d   = cnt - CNT_W'(1);
            end
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            md_busy <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            md_busy <= (state_d != IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if (accept && (Funct == FN_MTHI)) begin
            hi <= op_a;
        end else if (accept && (Funct == FN_MTLO)) begin
            lo <= op_a;
        end else if ((state == FIX) && !flush) begin
            hi <= fix_hi;
            lo <= fix_lo;
        end
    end

    md_iter #(
        .WIDTH(WIDTH)
    ) u_md_iter (
        .clk          (clk),
        .rst_n        (rst_n),
        .state        (state),
        .start        (start),
        .start_div    (f_div),
        .start_signed (start_signed),
        .op_a         (op_a),
        .op_b         (op_b),
        .fix_hi       (fix_hi),
        .fix_lo       (fix_lo)
    );

endmodule

// File: tb/tb_alu_control_md.sv
// ---------------------------------------------------------------------------
// tb_alu_control_md
// Directed bench for alu_control_md (WIDTH=32): a decode table plus
// hand-written multiply/divide, stall, flush and reset sequences.
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge or shortly after an input change.
// ---------------------------------------------------------------------------
module tb_alu_control_md;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       ALUOp;
    logic [5:0]       Funct;
    logic [5:0]       OpCode;
    logic             ex_valid;
    logic             flush;
    logic [WIDTH-1:0] op_a, op_b;
    logic [3:0]       ALUSel;
    logic             stall, md_busy;
    logic [WIDTH-1:0] hi, lo;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [5:0] T_MULT  = 6'b011000;
    localparam logic [5:0] T_MULTU = 6'b011001;
    localparam logic [5:0] T_DIV   = 6'b011010;
    localparam logic [5:0] T_DIVU  = 6'b011011;
    localparam logic [5:0] T_MTHI  = 6'b010001;
    localparam logic [5:0] T_MFLO  = 6'b010010;
    localparam logic [5:0] T_MTLO  = 6'b010011;

    always #5 clk = ~clk;

    alu_control_md #(
        .WIDTH(WIDTH),
        .SEL_W(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ALUOp    (ALUOp),
        .Funct    (Funct),
        .OpCode   (OpCode),
        .ex_valid (ex_valid),
        .flush    (flush),
        .op_a     (op_a),
        .op_b     (op_b),
        .ALUSel   (ALUSel),
        .stall    (stall),
        .md_busy  (md_busy),
        .hi       (hi),
        .lo       (lo)
    );

    typedef struct {
        logic [1:0] aluop;
        logic [5:0] funct;
        logic [5:0] opcode;
        logic [3:0] exp_sel;
    } dec_vec_t;

    dec_vec_t vecs[26];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Present a MULT*/DIV* for one edge (E0); returns at E0+1 with ex_valid low.
    task automatic start_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        ALUOp = 2'b10; Funct = f; op_a = a; op_b = b; ex_valid = 1'b1;
        @(negedge clk);
        check("accept_no_stall", stall, 0);
        @(posedge clk); #1;
        ex_valid = 1'b0;
    endtask

    // Count busy and stall samples until md_busy falls (bounded).
    task automatic wait_md(output int busy_n, output int stall_n);
        busy_n = 0;
        stall_n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!md_busy) break;
            busy_n++;
            if (stall) stall_n++;
        end
        check("wait_bound", md_busy, 0);
    endtask

    task automatic run_md(input string name, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
        int bn, sn;
        start_md(f, a, b);
        wait_md(bn, sn);
        check({name, "_busy"}, bn, 33);
        check({name, "_hi"}, hi, exp_hi);
        check({name, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bn, sn;

        vecs[0]  = '{2'b00, 6'b100100, 6'b000000, 4'b0000};
        vecs[1]  = '{2'b01, 6'b100100, 6'b000000, 4'b0001};
        vecs[2]  = '{2'b10, 6'b100000, 6'b000000, 4'b0000};
        vecs[3]  = '{2'b10, 6'b100001, 6'b000000, 4'b0000};
        vecs[4]  = '{2'b10, 6'b100010, 6'b000000, 4'b0001};
        vecs[5]  = '{2'b10, 6'b100011, 6'b000000, 4'b0001};
        vecs[6]  = '{2'b10, 6'b100100, 6'b000000, 4'b0010};
        vecs[7]  = '{2'b10, 6'b100101, 6'b000000, 4'b0011};
        vecs[8]  = '{2'b10, 6'b100110, 6'b000000, 4'b0100};
        vecs[9]  = '{2'b10, 6'b100111, 6'b000000, 4'b0101};
        vecs[10] = '{2'b10, 6'b101010, 6'b000000, 4'b0111};
        vecs[11] = '{2'b10, 6'b101011, 6'b000000, 4'b0110};
        vecs[12] = '{2'b10, 6'b000000, 6'b001111, 4'b1000};
        vecs[13] = '{2'b10, 6'b000010, 6'b000000, 4'b1001};
        vecs[14] = '{2'b10, 6'b000011, 6'b000000, 4'b1010};
        vecs[15] = '{2'b10, 6'b010000, 6'b000000, 4'b1100};
        vecs[16] = '{2'b10, 6'b010010, 6'b000000, 4'b1101};
        vecs[17] = '{2'b10, 6'b111111, 6'b000000, 4'b0000};
        vecs[18] = '{2'b11, 6'b100010, 6'b001010, 4'b0111};
        vecs[19] = '{2'b11, 6'b000000, 6'b001011, 4'b0110};
        vecs[20] = '{2'b11, 6'b000000, 6'b001100, 4'b0010};
        vecs[21] = '{2'b11, 6'b000000, 6'b001101, 4'b0011};
        vecs[22] = '{2'b11, 6'b000000, 6'b001110, 4'b0100};
        vecs[23] = '{2'b11, 6'b000000, 6'b001111, 4'b1011};
        vecs[24] = '{2'b11, 6'b000000, 6'b100011, 4'b0000};
        vecs[25] = '{2'b10, 6'b011000, 6'b000000, 4'b0000};

        // ---- reset state (MFHI presented to show stall stays low) ----
        rst_n = 1'b0; flush = 1'b0; ex_valid = 1'b1;
        ALUOp = 2'b10; Funct = 6'b010000; OpCode = '0; op_a = '0; op_b = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", md_busy, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_stall", stall, 0);
        check("rst_sel_mfhi", ALUSel, 4'b1100);
        ex_valid = 1'b0;
        rst_n = 1'b1;

        // ---- decode sweep ----
        for (int i = 0; i < 26; i++) begin
            ALUOp = vecs[i].aluop; Funct = vecs[i].funct; OpCode = vecs[i].opcode;
            #1;
            check($sformatf("dec%0d", i), ALUSel, vecs[i].exp_sel);
        end

        // ---- MULT -3 x 7 followed by a stalled MFLO ----
        start_md(T_MULT, 32'hFFFFFFFD, 32'd7);
        ALUOp = 2'b10; Funct = T_MFLO; ex_valid = 1'b1;
        wait_md(bn, sn);
        check("mult_busy_cycles", bn, 33);
        check("mflo_stall_cycles", sn, 33);
        check("mflo_stall_released", stall, 0);
        check("mflo_sel", ALUSel, 4'b1101);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFEB);
        @(posedge clk); #1;
        ex_valid = 1'b0;

        // ---- single operations ----
        run_md("divu_100_7",    T_DIVU,  32'd100,      32'd7,        32'd2,        32'd14);
        run_md("div_m7_2",      T_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        run_md("div_100_m7",    T_DIV,   32'd100,      32'hFFFFFFF9, 32'd2,        32'hFFFFFFF2);
        run_md("divu_by0",      T_DIVU,  32'h1234,     32'd0,        32'h1234,     32'hFFFFFFFF);
        run_md("div_neg_by0",   T_DIV,   32'hFFFFFF00, 32'd0,        32'hFFFFFF00, 32'hFFFFFFFF);
        run_md("div_min_m1",    T_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000);
        run_md("multu_max",     T_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_md("mult_m5_m6",    T_MULT,  32'hFFFFFFFB, 32'hFFFFFFFA, 32'd0,        32'd30);
        run_md("mult_max_min",  T_MULT,  32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000);

        // ---- MTLO while idle ----
        @(posedge clk); #1;
        ALUOp = 2'b10; Funct = T_MTLO; op_a = 32'h5A; ex_valid = 1'b1;
        @(negedge clk);
        check("mtlo_no_stall", stall, 0);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        @(negedge clk);
        check("mtlo_lo", lo, 32'h5A);
        check("mtlo_busy", md_busy, 0);

        // ---- back-to-back MULT then DIVU ----
        start_md(T_MULT, 32'd6, 32'd7);
        ALUOp = 2'b10; Funct = T_DIVU; op_a = 32'd100; op_b = 32'd7; ex_valid = 1'b1;
        wait_md(bn, sn);
        check("b2b_stall_cycles", sn, 33);
        check("b2b_mult_lo", lo, 32'd42);
        check("b2b_mult_hi", hi, 32'd0);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        wait_md(bn, sn);
        check("b2b_div_busy", bn, 33);
        check("b2b_div_lo", lo, 32'd14);
        check("b2b_div_hi", hi, 32'd2);

        // ---- MTHI during a busy MULT ----
        start_md(T_MULT, 32'd2, 32'd3);
        ALUOp = 2'b10; Funct = T_MTHI; op_a = 32'hABC; ex_valid = 1'b1;
        wait_md(bn, sn);
        check("mthi_stall_cycles", sn, 33);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        @(negedge clk);
        check("mthi_hi", hi, 32'hABC);
        check("mthi_lo", lo, 32'd6);

        // ---- flush mid-MULT with hi=0x11, lo=0x22 ----
        @(posedge clk); #1;
        ALUOp = 2'b10; Funct = T_MTHI; op_a = 32'h11; ex_valid = 1'b1;
        @(posedge clk); #1;
        Funct = T_MTLO; op_a = 32'h22;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        @(negedge clk);
        check("pre_flush_hi", hi, 32'h11);
        check("pre_flush_lo", lo, 32'h22);
        start_md(T_MULT, 32'd5, 32'd9);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("flush_busy_before", md_busy, 1);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_busy_after", md_busy, 0);
        check("flush_hi", hi, 32'h11);
        check("flush_lo", lo, 32'h22);
        repeat (40) @(negedge clk);
        check("flush_lo_late", lo, 32'h22);

        // ---- flush while idle blocks acceptance ----
        @(posedge clk); #1;
        ALUOp = 2'b10; Funct = T_MULT; op_a = 32'd3; op_b = 32'd3;
        ex_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        ex_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_idle_busy", md_busy, 0);

        // ---- asynchronous reset mid-DIV ----
        start_md(T_DIV, 32'd100, 32'd3);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_hi", hi, 0);
        check("arst_lo", lo, 0);
        check("arst_busy", md_busy, 0);
        #1 rst_n = 1'b1;

        // ---- recovery after reset ----
        run_md("mult_after_rst", T_MULT, 32'd3, 32'd4, 32'd0, 32'd12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_control_md.md
# alu_control_md

Parametrised execute-stage ALU control with an integrated iterative multiply/divide sequencer. Decodes ALUOp/Funct/OpCode into a 4-bit ALU select, a superset of the legacy 3-bit encoding. Also runs MIPS MULT/MULTU/DIV/DIVU over WIDTH+1 cycles into HI/LO registers. Stalls the pipeline only for HI/LO-class instructions that collide with a busy sequencer.

## Interface
- WIDTH, 32, datapath width; even, ≥ 4
- SEL_W, 4, ALUSel width; fixed at 4, exposed for package consistency
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ALUOp  in  2  class from main control: 00 add, 01 sub, 10 R-type, 11 I-type
- Funct  in  6  R-type function field
- OpCode  in  6  instruction opcode
- ex_valid  in  1  execute stage holds a live instruction
- flush  in  1  abort in-flight multiply/divide
- op_a  in  WIDTH  rs operand
- op_b  in  WIDTH  rt operand
- ALUSel  out  SEL_W  ALU operation select, combinational
- stall  out  1  hold execute stage, combinational
- md_busy  out  1  sequencer not IDLE, registered
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

## Operation
- ALUSel encodings: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, NOR 0101, SLTU 0110, SLT 0111, SLL 1000, SRL 1001, SRA 1010, LUI 1011, PASS_HI 1100, PASS_LO 1101. Legacy codes are unchanged.
- ALUOp 00 → ADD.
- ALUOp 01 → SUB.
- ALUOp 10, Funct decode:
  - 100000/100001 → ADD; 100010/100011 → SUB
  - 100100 → AND; 100101 → OR; 100110 → XOR; 100111 → NOR
  - 101010 → SLT; 101011 → SLTU
  - 000000 → SLL; 000010 → SRL; 000011 → SRA
  - 010000 (MFHI) → PASS_HI; 010010 (MFLO) → PASS_LO
  - any other Funct → ADD
- ALUOp 11, OpCode decode: 001010 → SLT; 001011 → SLTU; 001100 → AND; 001101 → OR; 001110 → XOR; 001111 → LUI; any other → ADD.
- MD class: ALUOp 10 and Funct one of MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MFHI, MTHI 010001, MFLO, MTLO 010011.
- FSM states:
  - IDLE: accept when ex_valid, MD class and not flush. MULT*/DIV* latch |op_a|, |op_b| (signed variants), result sign and remainder sign, then go to MUL or DIV. MTHI/MTLO write op_a to hi/lo at the edge and stay IDLE.
  - MUL/DIV: one radix-2 step per cycle, shift-add or restoring subtract. Counter runs WIDTH−1 down to 0; at 0 go to FIX.
  - FIX: apply sign negation, write hi/lo, go to IDLE.
- Signed multiply: {hi,lo} is the 2·WIDTH-bit two's-complement product.
- Signed divide: lo = quotient truncated toward zero; hi takes the sign of the dividend.
- Divisor zero (DIV or DIVU): lo = all ones, hi = op_a, no sign fix. Latency is unchanged.
- DIV of −2^(WIDTH−1) by −1: lo = 0x8…0, hi = 0.
- stall = ex_valid & MD class & md_busy. Non-MD instructions never stall.
- flush in MUL/DIV/FIX: next state IDLE, hi/lo unchanged. flush in IDLE blocks acceptance.

## Timing
- Reset: state IDLE, md_busy 0, hi 0, lo 0, counter 0. stall is 0 because md_busy is 0. ALUSel follows its inputs.
- Accept at edge E0; steps at E1…E32 (WIDTH=32); FIX writes hi/lo at E33. md_busy is high for WIDTH+1 cycles.
- An MD-class instruction presented the cycle after E0 sees stall for WIDTH+1 cycles. In the cycle after E33 it sees stall low and the new hi/lo.
- The accepting MULT/DIV itself is not stalled.
- rst_n low mid-operation: immediate IDLE and hi/lo cleared, asynchronously.
- Back-to-back MULT then DIV: the DIV is stalled, then accepted in the first IDLE cycle.

## Structure
- Package alu_ctrl_pkg holds:
  - ALUOp, OpCode and Funct constants
  - ALUSel encodings
  - FSM state enum {IDLE, MUL, DIV, FIX}
- Sub-module md_iter holds the datapath: operand/partial registers, step adder/subtractor and sign fixup, driven by state and counter from the parent.
- Counter width is $clog2(WIDTH).

## Test plan
- Decode sweep:
  - ALUOp=10, Funct=100111 → ALUSel 0101
  - ALUOp=11, OpCode=001111 → 1011
  - ALUOp=01 → 0001
  - ALUOp=10, Funct=111111 → 0000
- MULT 0xFFFFFFFD × 7 → hi 0xFFFFFFFF, lo 0xFFFFFFEB at E33; md_busy high 33 cycles. Following MFLO: stall 33 cycles, then ALUSel 1101 with lo 0xFFFFFFEB.
- DIVU 100 / 7 → lo 14, hi 2.
- DIV 0xFFFFFFF9 / 2 → lo 0xFFFFFFFD, hi 0xFFFFFFFF.
- DIVU 0x1234 / 0 → lo 0xFFFFFFFF, hi 0x1234.
- Abort cases, with prior hi=0x11, lo=0x22:
  - MULT, then flush at cycle 10 → md_busy 0 next cycle, hi/lo remain 0x11/0x22.
  - rst_n pulsed mid-DIV → hi/lo 0 immediately.
- MTLO with op_a=0x5A while idle → lo 0x5A next edge, no stall.
- MTHI during a busy MULT → stalled until IDLE, then hi = op_a.
